conv_ifmap_addr_gen_v2: RTL
===========================

// Module: conv_ifmap_addr_gen_v2
// PURPOSE
//  Parametrised dual-port input-feature-map address generator for the conv datapath.
//  Scans every output window (row i, column j) of every pass, with kernel taps, channels
//  per memory and memory groups nested inside. It presents two tap addresses per beat
//  to a true-dual-port ifmap RAM over a valid/ready handshake.
//  Adds zero-padding, odd tap counts, stall support, start/done and window/frame markers.
// PARAMETERS
//  ADDR_W      12  width of addr_a/addr_b
//  FM_W        5   input feature map width (pixels)
//  FM_H        5   input feature map height (pixels)
//  K           3   square kernel size (K>=1)
//  STRIDE      1   convolution stride (>=1)
//  PAD         0   zero-padding on each border (0..K-1)
//  CH_PER_MEM  1   feature maps stacked in one memory; channel base = ch*FM_W*FM_H
//  MEM_GROUPS  1   memory groups visited per window; index driven on mem_sel
//  PASSES      1   repeats of the full scan, one per output-map batch
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high
//  start        in   1   1-cycle pulse; begins a frame when idle; ignored while busy
//  ready        in   1   downstream accepts the current beat
//  valid        out  1   beat on outputs is valid
//  addr_a       out  ADDR_W  address of tap 2n
//  addr_b       out  ADDR_W  address of tap 2n+1
//  pad_a        out  1   tap 2n lies in padding; consumer substitutes 0; addr_a=0
//  pad_b        out  1   tap 2n+1 lies in padding; addr_b=0
//  b_valid      out  1   tap 2n+1 exists (0 on final beat when K*K is odd)
//  mem_sel      out  max(1,$clog2(MEM_GROUPS))  memory group of the current beat
//  window_last  out  1   last beat of a window (last tap pair, channel and group)
//  frame_last   out  1   last beat of the whole frame (all passes)
//  busy         out  1   FSM is not IDLE
//  done         out  1   1-cycle pulse after the frame_last beat is accepted
// BEHAVIOUR
//  Reset: FSM=IDLE; all counters 0; valid, pad_*, b_valid, window_last, frame_last,
//   busy and done are 0; addr_a, addr_b and mem_sel are 0. Reset mid-frame aborts at once.
//  Derived: OW=(FM_W+2*PAD-K)/STRIDE+1, OH likewise with FM_H, BEATS=ceil(K*K/2).
//  Loop order, inner to outer: beat n (0..BEATS-1), ch, grp, j (0..OW-1), i (0..OH-1),
//   pass. Each counter wraps to 0 when the next outer counter increments.
//  Tap t maps to km=t/K, kn=t%K. row=i*STRIDE+km-PAD, col=j*STRIDE+kn-PAD, computed
//   signed with ADDR_W+2 bits. pad=1 when row<0, row>=FM_H, col<0 or col>=FM_W;
//   otherwise addr=ch*FM_W*FM_H+row*FM_W+col, truncated to ADDR_W.
//  FSM IDLE -> RUN on start: first beat is registered, valid=1 the next cycle
//   (latency 1 from start).
//  RUN: a beat is accepted when valid&&ready. The next beat is loaded in the same edge,
//   so accepted beats can be back-to-back. With valid&&!ready, every output holds stable.
//  RUN -> DONE when the frame_last beat is accepted; valid drops that edge.
//  DONE: done=1 for one cycle, then -> IDLE. busy=1 in RUN and DONE.
//  start during RUN or DONE is ignored. start in the same cycle done is high is ignored.
//  ready is don't-care while valid=0. pad_b=0 whenever b_valid=0.
// TESTING
//  T1 defaults, start, ready=1: beats (0,1),(2,5),(6,7),(10,11),(12,b_valid=0);
//     window_last on beat 5; 45 beats total; frame_last on beat 45; done 1 cycle later.
//  T2 PAD=1, FM 4x4: window0 beats (pad,pad),(pad,pad),(0,1),(pad,4),(5,b_valid=0);
//     OW=OH=4; 80 beats total.
//  T3 STRIDE=2: OW=2; window j=1 begins (2,3); window i=1,j=0 begins (10,11); 20 beats.
//  T4 CH_PER_MEM=2, MEM_GROUPS=2: ch1 first beat (25,26); mem_sel toggles every 10 beats;
//     window_last every 20 beats.
//  T5 ready held low for 4 cycles mid-window: all outputs frozen, no beat lost or
//     repeated; random ready toggling yields the same beat sequence as T1.
//  T6 reset asserted mid-frame: valid, busy and all outputs go to 0 asynchronously;
//     a new start replays from beat (0,1); start during RUN has no effect.

Source files
------------

// File: rtl/conv_ifmap_addr_gen_v2.sv
// Dual-port ifmap address generator: walks every output window of every pass and
// presents two kernel-tap addresses per beat over a valid/ready handshake.
module conv_ifmap_addr_gen_v2 #(
  parameter int ADDR_W     = 12,
  parameter int FM_W       = 5,
  parameter int FM_H       = 5,
  parameter int K          = 3,
  parameter int STRIDE     = 1,
  parameter int PAD        = 0,
  parameter int CH_PER_MEM = 1,
  parameter int MEM_GROUPS = 1,
  parameter int PASSES     = 1,
  localparam int MS_W      = (MEM_GROUPS > 1) ? $clog2(MEM_GROUPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic              pad_a_o,
  output logic              pad_b_o,
  output logic              b_valid_o,
  output logic [MS_W-1:0]   mem_sel_o,
  output logic              window_last_o,
  output logic              frame_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a beat transfers on a rising edge where valid_o && ready_i; while
  // valid_o && !ready_i every beat output holds; ready_i is ignored while valid_o=0.

  localparam int OW    = (FM_W + 2 * PAD - K) / STRIDE + 1;
  localparam int OH    = (FM_H + 2 * PAD - K) / STRIDE + 1;
  localparam int TAPS  = K * K;
  localparam int BEATS = (TAPS + 1) / 2;
  localparam int CW    = 16;
  localparam int SW    = ADDR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              pad;
    logic [ADDR_W-1:0] addr;
  } tap_t;

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [CW-1:0] grp_q, grp_d;
  logic [CW-1:0] j_q, j_d;
  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] pass_q, pass_d;

  logic n_last, ch_last, grp_last, j_last, i_last, pass_last;
  logic win_last, frm_last;
  logic run;
  logic [CW-1:0] tap_a_idx, tap_b_idx;
  logic b_exists;
  tap_t tap_a, tap_b;

  // Row/column are signed so taps above or left of the map fall into padding.
  function automatic tap_t tap_addr(input logic [CW-1:0] t, input logic [CW-1:0] i,
                                    input logic [CW-1:0] j, input logic [CW-1:0] ch);
    logic signed [SW-1:0] row;
    logic signed [SW-1:0] col;
    tap_t r;
    row = SW'(i * STRIDE) + SW'(t / K) - SW'(PAD);
    col = SW'(j * STRIDE) + SW'(t % K) - SW'(PAD);
    r.pad = row[SW-1] || (row >= SW'(FM_H)) || col[SW-1] || (col >= SW'(FM_W));
    r.addr = r.pad ? '0 : ADDR_W'(ch * FM_W * FM_H) + ADDR_W'(row * FM_W) + ADDR_W'(col);
    return r;
  endfunction

  assign n_last    = (n_q == CW'(BEATS - 1));
  assign ch_last   = (ch_q == CW'(CH_PER_MEM - 1));
  assign grp_last  = (grp_q == CW'(MEM_GROUPS - 1));
  assign j_last    = (j_q == CW'(OW - 1));
  assign i_last    = (i_q == CW'(OH - 1));
  assign pass_last = (pass_q == CW'(PASSES - 1));
  assign win_last  = n_last && ch_last && grp_last;
  assign frm_last  = win_last && j_last && i_last && pass_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      ch_q    <= '0;
      grp_q   <= '0;
      j_q     <= '0;
      i_q     <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      ch_q    <= ch_d;
      grp_q   <= grp_d;
      j_q     <= j_d;
      i_q     <= i_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    ch_d    = ch_q;
    grp_d   = grp_q;
    j_d     = j_q;
    i_d     = i_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          n_d     = '0;
          ch_d    = '0;
          grp_d   = '0;
          j_d     = '0;
          i_d     = '0;
          pass_d  = '0;
        end
      end
      S_RUN: begin
        if (ready_i) begin
          // Odometer advance; on the final beat every counter wraps back to 0.
          if (!n_last) begin
            n_d = n_q + 1'b1;
          end else begin
            n_d = '0;
            if (!ch_last) begin
              ch_d = ch_q + 1'b1;
            end else begin
              ch_d = '0;
              if (!grp_last) begin
                grp_d = grp_q + 1'b1;
              end else begin
                grp_d = '0;
                if (!j_last) begin
                  j_d = j_q + 1'b1;
                end else begin
                  j_d = '0;
                  if (!i_last) begin
                    i_d = i_q + 1'b1;
                  end else begin
                    i_d    = '0;
                    pass_d = pass_last ? '0 : pass_q + 1'b1;
                  end
                end
              end
            end
          end
          if (frm_last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign run       = (state_q == S_RUN);
  assign tap_a_idx = {n_q[CW-2:0], 1'b0};
  assign tap_b_idx = {n_q[CW-2:0], 1'b1};
  assign b_exists  = (tap_b_idx < CW'(TAPS));

  always_comb begin
    tap_a = tap_addr(tap_a_idx, i_q, j_q, ch_q);
    tap_b = tap_addr(tap_b_idx, i_q, j_q, ch_q);
  end

  // Beat outputs decode straight from registered counters, zeroed outside RUN.
  assign valid_o       = run;
  assign addr_a_o      = run ? tap_a.addr : '0;
  assign pad_a_o       = run && tap_a.pad;
  assign b_valid_o     = run && b_exists;
  assign addr_b_o      = (run && b_exists) ? tap_b.addr : '0;
  assign pad_b_o       = run && b_exists && tap_b.pad;
  assign mem_sel_o     = run ? grp_q[MS_W-1:0] : '0;
  assign window_last_o = run && win_last;
  assign frame_last_o  = run && frm_last;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign dbg_state_o   = state_q;

endmodule
